// File: rtl/fe_capture_ctrl_pkg.sv
// Shared definitions for the front-end capture run controller: state
// encodings, readback width and the default pipeline flush length.
package fe_capture_ctrl_pkg;

  localparam int FE_CTRL_STATE_WIDTH   = 3;
  localparam int FE_CTRL_FLUSH_DEFAULT = 4;

  typedef enum logic [FE_CTRL_STATE_WIDTH-1:0] {
    FE_CTRL_S_IDLE    = 3'd0,
    FE_CTRL_S_ARMED   = 3'd1,
    FE_CTRL_S_DELAY   = 3'd2,
    FE_CTRL_S_CAPTURE = 3'd3,
    FE_CTRL_S_DRAIN   = 3'd4,
    FE_CTRL_S_DONE    = 3'd5
  } fe_ctrl_state_e;

  // Waiting for the trigger or counting out the post-trigger delay.
  function automatic logic fe_ctrl_is_armed(input fe_ctrl_state_e s);
    return (s == FE_CTRL_S_ARMED) || (s == FE_CTRL_S_DELAY);
  endfunction

endpackage

// File: rtl/fe_capture_ctrl_if.sv
// Command/status bundle between the capture run controller and its
// register file / capture engine side.
interface fe_capture_ctrl_if
  import fe_capture_ctrl_pkg::*;
#(
  parameter int pCAP_LEN_WIDTH = 20,
  parameter int pDELAY_WIDTH   = 16
);

  logic                           arm;
  logic                           abort;
  logic                           trigger;
  logic                           trigger_bypass;
  logic [pDELAY_WIDTH-1:0]        trigger_delay;
  logic [pCAP_LEN_WIDTH-1:0]      capture_len;
  logic                           fifo_full;
  logic                           fifo_wr;

  logic                           capture_enable;
  logic                           armed;
  logic                           capturing;
  logic                           done;
  logic                           overflow;
  logic [pCAP_LEN_WIDTH-1:0]      entry_count;
  logic [FE_CTRL_STATE_WIDTH-1:0] state;

  modport master (
    output arm, abort, trigger, trigger_bypass, trigger_delay, capture_len,
           fifo_full, fifo_wr,
    input  capture_enable, armed, capturing, done, overflow, entry_count, state
  );

  modport slave (
    input  arm, abort, trigger, trigger_bypass, trigger_delay, capture_len,
           fifo_full, fifo_wr,
    output capture_enable, armed, capturing, done, overflow, entry_count, state
  );

endinterface

// File: rtl/fe_capture_ctrl_cnt.sv
// Loadable down-counter with zero / one detect. Holds at zero.
module fe_capture_ctrl_cnt #(
  parameter int pWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [pWIDTH-1:0] load_val,
  input  logic              dec,
  output logic              is_zero,
  output logic              is_one
);

  logic [pWIDTH-1:0] count;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == pWIDTH'(1));

endmodule

// File: rtl/fe_capture_ctrl.sv
// Run-control sequencer for the front-end capture datapath.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no run; waits for arm
//   ARMED   | run armed, waiting for trigger
//   DELAY   | trigger seen, counting post-trigger delay
//   CAPTURE | capture engine enabled, counting FIFO writes
//   DRAIN   | enable dropped, flushing late pipeline writes
//   DONE    | run finished (length reached or FIFO full); re-armable
module fe_capture_ctrl
  import fe_capture_ctrl_pkg::*;
#(
  parameter int pCAP_LEN_WIDTH = 20,
  parameter int pDELAY_WIDTH   = 16,
  parameter int pFLUSH_CYCLES  = FE_CTRL_FLUSH_DEFAULT
) (
  input logic              fe_clk,
  input logic              reset_n,
  fe_capture_ctrl_if.slave bus
);

  localparam int FLUSH_W = $clog2(pFLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(pFLUSH_CYCLES);

  fe_ctrl_state_e state, state_nxt;

  logic [pCAP_LEN_WIDTH-1:0] entry_count;
  logic [pCAP_LEN_WIDTH:0]   count_with_wr;
  logic                      done_q, overflow_q, aborted_q;
  logic                      cap_en_q, armed_q, capturing_q;
  logic                      run_start, drain_start, drain_end;
  logic                      dly_load, dly_zero, dly_one;
  logic                      flush_zero, flush_one;
  logic                      len_reached, wr_counted;

  fe_capture_ctrl_cnt #(.pWIDTH(pDELAY_WIDTH)) u_delay_cnt (
    .clk      (fe_clk),
    .rst_n    (reset_n),
    .load     (dly_load),
    .load_val (bus.trigger_delay),
    .dec      (state == FE_CTRL_S_DELAY),
    .is_zero  (dly_zero),
    .is_one   (dly_one)
  );

  fe_capture_ctrl_cnt #(.pWIDTH(FLUSH_W)) u_flush_cnt (
    .clk      (fe_clk),
    .rst_n    (reset_n),
    .load     (drain_start),
    .load_val (FLUSH_LOAD),
    .dec      (state == FE_CTRL_S_DRAIN),
    .is_zero  (flush_zero),
    .is_one   (flush_one)
  );

  // Include the write arriving this cycle so enable drops right after the last wanted one.
  assign count_with_wr = {1'b0, entry_count} + {{pCAP_LEN_WIDTH{1'b0}}, bus.fifo_wr};
  assign len_reached   = (bus.capture_len != '0) && (count_with_wr >= {1'b0, bus.capture_len});
  assign wr_counted    = bus.fifo_wr &&
                         ((state == FE_CTRL_S_CAPTURE) || (state == FE_CTRL_S_DRAIN));

  // State register; reset forces IDLE asynchronously.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state <= FE_CTRL_S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; abort outranks trigger, length and FIFO-full.
  always_comb begin
    state_nxt   = state;
    run_start   = 1'b0;
    dly_load    = 1'b0;
    drain_start = 1'b0;
    drain_end   = 1'b0;
    case (state)
      FE_CTRL_S_IDLE, FE_CTRL_S_DONE: begin
        if (bus.arm) begin
          run_start = 1'b1;
          state_nxt = bus.trigger_bypass ? FE_CTRL_S_CAPTURE : FE_CTRL_S_ARMED;
        end
      end
      FE_CTRL_S_ARMED: begin
        if (bus.abort) begin
          state_nxt = FE_CTRL_S_IDLE;
        end else if (bus.trigger) begin
          if (bus.trigger_delay == '0) begin
            state_nxt = FE_CTRL_S_CAPTURE;
          end else begin
            state_nxt = FE_CTRL_S_DELAY;
            dly_load  = 1'b1;
          end
        end
      end
      FE_CTRL_S_DELAY: begin
        if (bus.abort)                state_nxt = FE_CTRL_S_IDLE;
        else if (dly_one || dly_zero) state_nxt = FE_CTRL_S_CAPTURE;
      end
      FE_CTRL_S_CAPTURE: begin
        if (bus.abort || len_reached || bus.fifo_full) begin
          state_nxt   = FE_CTRL_S_DRAIN;
          drain_start = 1'b1;
        end
      end
      FE_CTRL_S_DRAIN: begin
        if (flush_one || flush_zero) begin
          drain_end = 1'b1;
          state_nxt = aborted_q ? FE_CTRL_S_IDLE : FE_CTRL_S_DONE;
        end
      end
      default: state_nxt = FE_CTRL_S_IDLE;
    endcase
  end

  // Saturating entry counter; live only while capturing or draining.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_count <= '0;
    end else if (run_start) begin
      entry_count <= '0;
    end else if (wr_counted && (entry_count != '1)) begin
      entry_count <= entry_count + 1'b1;
    end
  end

  // Sticky run status flags, all cleared by an accepted arm.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else if (run_start) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      if (wr_counted && bus.fifo_full)               overflow_q <= 1'b1;
      if ((state == FE_CTRL_S_CAPTURE) && bus.abort) aborted_q  <= 1'b1;
      if (drain_end && !aborted_q)                   done_q     <= 1'b1;
    end
  end

  // Decoded outputs registered from next state so they line up with the state register.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_en_q    <= 1'b0;
      armed_q     <= 1'b0;
      capturing_q <= 1'b0;
    end else begin
      cap_en_q    <= (state_nxt == FE_CTRL_S_CAPTURE);
      armed_q     <= fe_ctrl_is_armed(state_nxt);
      capturing_q <= (state_nxt == FE_CTRL_S_CAPTURE);
    end
  end

  assign bus.capture_enable = cap_en_q;
  assign bus.armed          = armed_q;
  assign bus.capturing      = capturing_q;
  assign bus.done           = done_q;
  assign bus.overflow       = overflow_q;
  assign bus.entry_count    = entry_count;
  assign bus.state          = state;

endmodule

// File: tb/tb_fe_capture_ctrl.sv
// Bench for the capture run controller. A capture-engine model turns
// capture_enable into FIFO writes three cycles later. Stimulus pushes
// cycle-stamped expected snapshots; the monitor compares each one in its
// cycle and also demands that every state change was announced.
module tb_fe_capture_ctrl;

  localparam int CW    = 10;
  localparam int DW    = 16;
  localparam int FLUSH = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b0;

  fe_capture_ctrl_if #(.pCAP_LEN_WIDTH(CW), .pDELAY_WIDTH(DW)) bus ();

  fe_capture_ctrl #(
    .pCAP_LEN_WIDTH (CW),
    .pDELAY_WIDTH   (DW),
    .pFLUSH_CYCLES  (FLUSH)
  ) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 fe_clk = ~fe_clk;

  int cyc = 0;
  always @(posedge fe_clk) cyc = cyc + 1;

  logic [2:0] pipe   = '0;
  logic       man_wr = 1'b0;
  always @(posedge fe_clk) pipe <= {pipe[1:0], bus.capture_enable};
  assign bus.fifo_wr = pipe[2] | man_wr;

  typedef struct {
    int            cyc;
    logic [2:0]    st;
    logic          dn;
    logic          ov;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t       sbq[$];
  int         n_vec  = 0;
  int         n_err  = 0;
  bit         mon_on = 1'b0;
  logic [2:0] prev_st;

  task automatic sb_push(input int off, input logic [2:0] st, input logic dn,
                         input logic ov, input int cnt, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.st   = st;
    e.dn   = dn;
    e.ov   = ov;
    e.cnt  = CW'(cnt);
    e.name = name;
    sbq.push_back(e);
  endtask

  always @(negedge fe_clk) begin
    if (mon_on) begin
      bit   hit;
      logic exp_en, exp_arm;
      hit = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        n_vec = n_vec + 1;
        if (e.cyc < cyc) begin
          n_err = n_err + 1;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
        end else begin
          hit     = 1'b1;
          exp_en  = (e.st == S_CAP);
          exp_arm = (e.st == S_ARMED) || (e.st == S_DELAY);
          if (bus.state !== e.st || bus.capture_enable !== exp_en ||
              bus.capturing !== exp_en || bus.armed !== exp_arm ||
              bus.done !== e.dn || bus.overflow !== e.ov || bus.entry_count !== e.cnt) begin
            n_err = n_err + 1;
            $display("FAIL %s @%0d: got st=%0d en=%b cap=%b arm=%b done=%b ovf=%b cnt=%0d, want st=%0d en=%b cap=%b arm=%b done=%b ovf=%b cnt=%0d",
                     e.name, cyc, bus.state, bus.capture_enable, bus.capturing, bus.armed,
                     bus.done, bus.overflow, bus.entry_count,
                     e.st, exp_en, exp_en, exp_arm, e.dn, e.ov, e.cnt);
          end
        end
      end
      if (bus.state !== prev_st && !hit) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_transition @%0d: got state %0d from %0d, want no change",
                 cyc, bus.state, prev_st);
      end
      prev_st = bus.state;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge fe_clk);
    #1;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    step(1);
    bus.arm = 1'b0;
  endtask

  initial begin
    bus.arm            = 1'b0;
    bus.abort          = 1'b0;
    bus.trigger        = 1'b0;
    bus.trigger_bypass = 1'b0;
    bus.trigger_delay  = '0;
    bus.capture_len    = '0;
    bus.fifo_full      = 1'b0;

    step(3);
    reset_n = 1'b1;
    prev_st = bus.state;
    mon_on  = 1'b1;
    sb_push(1, S_IDLE, 0, 0, 0, "reset_state");
    step(2);

    // 1: bypass, len 10, engine writes every cycle once enabled
    bus.trigger_bypass = 1'b1;
    bus.capture_len    = CW'(10);
    sb_push(1,  S_CAP,   0, 0, 0,  "t1_enable");
    sb_push(13, S_CAP,   0, 0, 9,  "t1_cnt9");
    sb_push(14, S_DRAIN, 0, 0, 10, "t1_len_stop");
    sb_push(18, S_DONE,  1, 0, 13, "t1_done");
    pulse_arm();
    step(20);

    // 2: triggered, delay 5; trigger in the arm cycle is not seen
    bus.trigger_bypass = 1'b0;
    bus.trigger_delay  = DW'(5);
    bus.trigger        = 1'b1;
    sb_push(1,  S_ARMED, 0, 0, 0,  "t2_armed_clear");
    sb_push(10, S_ARMED, 0, 0, 0,  "t2_wait");
    sb_push(21, S_DELAY, 0, 0, 0,  "t2_delay");
    sb_push(25, S_DELAY, 0, 0, 0,  "t2_delay_last");
    sb_push(26, S_CAP,   0, 0, 0,  "t2_enable");
    sb_push(39, S_DRAIN, 0, 0, 10, "t2_len_stop");
    sb_push(43, S_DONE,  1, 0, 13, "t2_done");
    pulse_arm();
    bus.trigger = 1'b0;
    step(19);
    bus.trigger = 1'b1;
    step(1);
    bus.trigger = 1'b0;
    step(25);

    // 3: unlimited length, FIFO full at the 100th write, then re-arm
    bus.trigger_bypass = 1'b1;
    bus.capture_len    = '0;
    sb_push(1,   S_CAP,   0, 0, 0,   "t3_enable");
    sb_push(104, S_DRAIN, 0, 1, 100, "t3_full_stop");
    sb_push(108, S_DONE,  1, 1, 103, "t3_done_ovf");
    pulse_arm();
    step(102);
    bus.fifo_full = 1'b1;
    step(10);
    bus.fifo_full      = 1'b0;
    bus.trigger_bypass = 1'b0;
    bus.trigger_delay  = DW'(3);
    sb_push(1, S_ARMED, 0, 0, 0, "t3_rearm_clear");
    pulse_arm();
    step(2);

    // 4a: abort together with trigger in ARMED
    bus.abort   = 1'b1;
    bus.trigger = 1'b1;
    sb_push(1, S_IDLE, 0, 0, 0, "t4_abort_armed");
    sb_push(6, S_IDLE, 0, 0, 0, "t4_no_enable");
    step(1);
    bus.abort   = 1'b0;
    bus.trigger = 1'b0;
    step(8);

    // 4b: abort mid-capture drains then returns to IDLE without done
    bus.trigger_bypass = 1'b1;
    sb_push(1,  S_CAP,   0, 0, 0,  "t4_enable");
    sb_push(21, S_DRAIN, 0, 0, 17, "t4_abort_cap");
    sb_push(24, S_DRAIN, 0, 0, 20, "t4_drain_last");
    sb_push(25, S_IDLE,  0, 0, 20, "t4_aborted_idle");
    pulse_arm();
    step(19);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    step(10);

    // 5: arm ignored in DELAY and CAPTURE, then async reset mid-capture
    bus.trigger_bypass = 1'b0;
    bus.trigger_delay  = DW'(6);
    sb_push(1,  S_ARMED, 0, 0, 0, "t5_armed");
    sb_push(4,  S_DELAY, 0, 0, 0, "t5_delay");
    sb_push(10, S_CAP,   0, 0, 0, "t5_enable");
    sb_push(22, S_CAP,   0, 0, 9, "t5_arm_ignored");
    sb_push(25, S_IDLE,  0, 0, 0, "t5_async_reset");
    sb_push(30, S_IDLE,  0, 0, 0, "t5_idle_wr_ignored");
    pulse_arm();
    step(2);
    bus.trigger = 1'b1;
    step(1);
    bus.trigger = 1'b0;
    step(2);
    bus.arm = 1'b1;
    step(1);
    bus.arm = 1'b0;
    step(13);
    bus.trigger_bypass = 1'b1;
    bus.arm            = 1'b1;
    step(1);
    bus.arm = 1'b0;
    step(4);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(5);

    // 6a: zero delay, len 5; writes in DONE are not counted
    bus.trigger_bypass = 1'b0;
    bus.trigger_delay  = '0;
    bus.capture_len    = CW'(5);
    sb_push(1,  S_ARMED, 0, 0, 0, "t6_armed");
    sb_push(5,  S_CAP,   0, 0, 0, "t6_delay0");
    sb_push(13, S_DRAIN, 0, 0, 5, "t6_len_stop");
    sb_push(17, S_DONE,  1, 0, 8, "t6_done");
    sb_push(22, S_DONE,  1, 0, 8, "t6_done_wr_ignored");
    pulse_arm();
    step(3);
    bus.trigger = 1'b1;
    step(1);
    bus.trigger = 1'b0;
    step(13);
    man_wr = 1'b1;
    step(3);
    man_wr = 1'b0;
    step(3);

    // 6b: entry counter saturates at all-ones
    bus.trigger_bypass = 1'b1;
    bus.capture_len    = '0;
    sb_push(1,    S_CAP,   0, 0, 0,    "t6_sat_enable");
    sb_push(1026, S_CAP,   0, 0, 1022, "t6_sat_minus1");
    sb_push(1027, S_CAP,   0, 0, 1023, "t6_sat_reach");
    sb_push(1040, S_CAP,   0, 0, 1023, "t6_saturated");
    sb_push(1041, S_DRAIN, 0, 0, 1023, "t6_sat_abort");
    sb_push(1045, S_IDLE,  0, 0, 1023, "t6_sat_idle");
    pulse_arm();
    step(1039);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    step(8);

    n_vec = n_vec + 1;
    if (sbq.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
